// File: rtl/pio_in_pkg.sv
// Shared constants for the Avalon-MM input PIO: register addresses,
// edge-mode encodings and the per-bit edge detector.
// Optional feature macro used by this slice: PIO_IN_DEBOUNCE_EN.
package pio_in_pkg;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd1;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int DEBOUNCE_CNT_W = 16;

    // One-bit edge detector: compares the filtered value with its delayed copy.
    function automatic logic bit_edge(input logic cur, input logic prev, input int mode);
        case (mode)
            EDGE_RISE: return cur & ~prev;
            EDGE_FALL: return ~cur & prev;
            default:   return cur ^ prev;
        endcase
    endfunction

endpackage

// File: rtl/pio_in_bit_filter.sv
// One input bit: two-flop synchroniser followed, when PIO_IN_DEBOUNCE_EN is
// defined, by a counter-based debounce filter. Without the macro the filtered
// value is the synchronised value and no counter exists.
module pio_in_bit_filter
    import pio_in_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din_i,
    output logic dout_o
);

    logic sync1_q;
    logic sync2_q;

    // Bring the asynchronous pin into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let sync2_q take the old sync1_q,
            // giving two real flop stages instead of one.
            sync1_q <= din_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef PIO_IN_DEBOUNCE_EN
    localparam logic [DEBOUNCE_CNT_W-1:0] CNT_LAST = DEBOUNCE_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [DEBOUNCE_CNT_W-1:0] cnt_q, cnt_d;
    logic                      filt_q, filt_d;

    // Count consecutive cycles the synced value disagrees with the filtered
    // one; flip once the disagreement has lasted DEBOUNCE_CYCLES samples.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign dout_o = filt_q;
`else
    logic unused_cfg;
    assign unused_cfg = (DEBOUNCE_CYCLES == 0);
    assign dout_o     = sync2_q;
`endif

endmodule

// File: rtl/avalon_pio_in_irq.sv
// Avalon-MM input PIO with per-bit synchronisation, edge capture and a
// maskable level interrupt. Registers: DATA (0, RO), MASK (1, RW),
// reserved (2), EDGE (3, write-1-to-clear). Read latency is one cycle.
// Optional debounce filter enabled by defining PIO_IN_DEBOUNCE_EN.
module avalon_pio_in_irq
    import pio_in_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int EDGE_MODE       = EDGE_RISE,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] det_raw;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       warm_q, warm_d;
    logic             warm_done;
    logic             wr_en;
    logic             rd_en;
    logic             unused_ok;

    // Per-bit synchroniser/filter and edge detector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_in_bit_filter #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_filter (
            .clk    (clk),
            .reset_n(reset_n),
            .din_i  (in_port[i]),
            .dout_o (filt[i])
        );
        assign det_raw[i] = bit_edge(filt[i], prev_q[i], EDGE_MODE);
    end

    assign warm_done = (warm_q == 2'd3);
    assign warm_d    = warm_done ? warm_q : warm_q + 2'd1;
    assign det       = warm_done ? det_raw : '0;
    assign wr_en     = chipselect && !write_n;
    assign rd_en     = chipselect && write_n;
    assign unused_ok = &{1'b0, writedata};

    // Warm-up counter and delayed copy of the filtered inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_q <= 2'd0;
            prev_q <= '0;
        end else begin
            warm_q <= warm_d;
            prev_q <= filt;
        end
    end

    // Next-state for MASK, EDGE and the registered read data.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        mask_d  = mask_q;
        clr     = '0;
        rdata_d = rdata_q;
        if (wr_en && address == PIO_ADDR_MASK) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == PIO_ADDR_EDGE) begin
            clr = writedata[WIDTH-1:0];
        end
        // A new detection on a bit being cleared keeps the bit set.
        edge_d = (edge_q & ~clr) | det;
        if (rd_en) begin
            case (address)
                PIO_ADDR_DATA: rdata_d = 32'(filt);
                PIO_ADDR_MASK: rdata_d = 32'(mask_q);
                PIO_ADDR_EDGE: rdata_d = 32'(edge_q);
                default:       rdata_d = '0;
            endcase
        end
    end

    // Software-visible registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q  <= '0;
            edge_q  <= '0;
            rdata_q <= '0;
        end else begin
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_avalon_pio_in_irq.sv
// Directed bench for avalon_pio_in_irq: a rising-edge instance and an
// any-edge instance share the bus and inputs. Debounce timing is exercised
// when PIO_IN_DEBOUNCE_EN is defined.
module tb_avalon_pio_in_irq;

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata, readdata_any;
    logic        irq, irq_any;

    int checks = 0;
    int errors = 0;

    avalon_pio_in_irq #(.WIDTH(8), .EDGE_MODE(0), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    avalon_pio_in_irq #(.WIDTH(8), .EDGE_MODE(2), .DEBOUNCE_CYCLES(4)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_any),
        .in_port(in_port), .irq(irq_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        chipselect = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 8'hFF;

        // Reset state with inputs held high
        ticks(2);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        check("reset_irq_any", {31'b0, irq_any}, 32'h0);
        reset_n = 1'b1;
        ticks(6 + DB);
        bus_read(2'd0);
        check("warm_data", readdata, 32'hFF);
        bus_read(2'd3);
        check("warm_edge", readdata, (DB != 0) ? 32'hFF : 32'h0);
        check("warm_edge_any", readdata_any, (DB != 0) ? 32'hFF : 32'h0);
        check("warm_irq", {31'b0, irq}, 32'h0);

        // Drop all inputs and clear whatever was captured
        in_port = 8'h00;
        ticks(8 + DB);
        bus_write(2'd3, 32'hFF);
        bus_read(2'd3);
        check("clr_all_edge", readdata, 32'h0);
        check("clr_all_edge_any", readdata_any, 32'h0);

        // Rising edge on bit 0 with MASK=01: exact DATA/irq latency
        bus_write(2'd1, 32'h01);
        check("mask01_irq_idle", {31'b0, irq}, 32'h0);
        in_port = 8'h01;
        ticks(1 + DB);
        bus_read(2'd0);
        check("data_before", readdata, 32'h00);
        check("irq_before", {31'b0, irq}, 32'h0);
        bus_read(2'd0);
        check("data_after", readdata, 32'h01);
        check("irq_n3", {31'b0, irq}, 32'h1);
        bus_read(2'd3);
        check("edge_bit0", readdata, 32'h01);
        bus_write(2'd3, 32'h01);
        check("irq_cleared", {31'b0, irq}, 32'h0);

        // Detection on bit 1 in the same cycle as its clear: set wins
        in_port = 8'h03;
        ticks(2 + DB);
        bus_write(2'd3, 32'h02);
        bus_read(2'd3);
        check("set_wins_edge", readdata, 32'h02);
        check("set_wins_irq", {31'b0, irq}, 32'h0);
        bus_write(2'd3, 32'h02);
        bus_read(2'd3);
        check("set_wins_cleared", readdata, 32'h00);

        // Reserved address and upper bits of MASK
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd2);
        check("reserved_read", readdata, 32'h0);
        bus_write(2'd1, 32'hFFFF_FF00);
        bus_read(2'd1);
        check("mask_upper_zero", readdata, 32'h0);

        // Masked capture on bit 3, then unmask
        in_port = 8'h0B;
        ticks(3 + DB);
        check("masked_irq", {31'b0, irq}, 32'h0);
        bus_read(2'd3);
        check("masked_edge", readdata, 32'h08);
        bus_write(2'd1, 32'h08);
        check("unmask_irq", {31'b0, irq}, 32'h1);
        bus_write(2'd3, 32'h08);
        check("unmask_clr_irq", {31'b0, irq}, 32'h0);

        // readdata holds while no read is issued
        bus_read(2'd1);
        check("mask_read", readdata, 32'h08);
        ticks(3);
        bus_write(2'd2, 32'h0);
        check("readdata_hold", readdata, 32'h08);

        // Any-edge instance: rise and fall of bit 7, ten cycles apart
        bus_write(2'd3, 32'hFF);
        bus_write(2'd1, 32'h80);
        in_port = 8'h8B;
        ticks(3 + DB);
        check("rise7_irq_any", {31'b0, irq_any}, 32'h1);
        check("rise7_irq", {31'b0, irq}, 32'h1);
        bus_read(2'd3);
        check("rise7_edge_any", readdata_any, 32'h80);
        check("rise7_edge", readdata, 32'h80);
        bus_write(2'd3, 32'h80);
        check("rise7_clr_any", {31'b0, irq_any}, 32'h0);
        ticks(5);
        in_port = 8'h0B;
        ticks(3 + DB);
        check("fall7_irq_any", {31'b0, irq_any}, 32'h1);
        check("fall7_irq", {31'b0, irq}, 32'h0);
        bus_read(2'd3);
        check("fall7_edge_any", readdata_any, 32'h80);
        check("fall7_edge", readdata, 32'h00);

`ifdef PIO_IN_DEBOUNCE_EN
        // 3-cycle glitch on bit 2 is filtered out
        in_port = 8'h0F;
        ticks(3);
        in_port = 8'h0B;
        ticks(8);
        bus_read(2'd0);
        check("glitch_data", readdata, 32'h0B);
        // 6-cycle level on bit 2 reaches DATA after 2+4 cycles
        in_port = 8'h0F;
        ticks(5);
        bus_read(2'd0);
        check("level_data_early", readdata, 32'h0B);
        in_port = 8'h0B;
        bus_read(2'd0);
        check("level_data", readdata, 32'h0F);
        ticks(12);
`endif

        // Asynchronous reset in mid-cycle clears state at once
        check("pre_reset_irq_any", {31'b0, irq_any}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("async_irq_any", {31'b0, irq_any}, 32'h0);
        check("async_readdata_any", readdata_any, 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        ticks(6 + DB);
        bus_read(2'd1);
        check("post_reset_mask", readdata, 32'h0);
        bus_read(2'd3);
        check("post_reset_edge", readdata, (DB != 0) ? 32'h0B : 32'h0);
        bus_read(2'd0);
        check("post_reset_data", readdata, 32'h0B);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
